gpr_mp: RTL

Parametrised multi-port general-purpose register file. It is the next-generation replacement for the single-write, two-read GPR in the datapath. Adds:
- configurable width, depth and read-port count
- a second write port
- a per-register pending scoreboard for hazard detection
- a sequenced bulk-clear engine, so software or a pipeline flush can zero the file without a reset.

---
 rtl/gpr_mp.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gpr_mp.sv
// gpr_mp: parametrised multi-port register file with two write ports, a
// per-register pending scoreboard and a sequenced bulk-clear engine.
// Optional build macro GPR_BYPASS_EN enables same-cycle write-to-read
// forwarding; without it, writes become visible on the following cycle.
module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_clr_busy;
    logic                r_clr_done;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;

    logic                w_idle;
    logic                w_sweep;
    logic                w_wr0_ok;
    logic                w_wr1_ok;
    logic                w_sb_ok;
    logic [ADDR_W-1:0]   w_ra;

    // True when the address names the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // State register; clr_busy/clr_done are registered from the next state
    // so they line up exactly with SWEEP and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= (r_state == S_SWEEP) ? r_idx + 1'b1 : '0;
            r_clr_busy <= (w_state_nxt == S_SWEEP);
            r_clr_done <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state logic: IDLE samples clr_req, SWEEP walks every index once,
    // DONE lasts one cycle and always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/qualifier logic: writes and scoreboard sets only act in IDLE,
    // never on the zero register, and wr1 shadows wr0 on a shared address.
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_sweep  = (r_state == S_SWEEP);
        w_wr1_ok = wr1_en && w_idle && !is_zero_reg(wr1_addr);
        w_wr0_ok = wr0_en && w_idle && !is_zero_reg(wr0_addr)
                   && !(w_wr1_ok && (wr1_addr == wr0_addr));
        w_sb_ok  = sb_set_en && w_idle && !is_zero_reg(sb_set_addr);
    end

    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;

    // Register array: sweep clear has priority, otherwise wr1 over wr0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_sweep && (r_idx == ADDR_W'(i)))
                    r_regs[i] <= '0;
                else if (w_wr1_ok && (wr1_addr == ADDR_W'(i)))
                    r_regs[i] <= wr1_data;
                else if (w_wr0_ok && (wr0_addr == ADDR_W'(i)))
                    r_regs[i] <= wr0_data;
            end
        end
    end

    // Pending scoreboard: sweep clears, a set beats a same-cycle write,
    // and any committed write retires the pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_sweep && (r_idx == ADDR_W'(i)))
                    r_pend[i] <= 1'b0;
                else if (w_sb_ok && (sb_set_addr == ADDR_W'(i)))
                    r_pend[i] <= 1'b1;
                else if ((w_wr1_ok && (wr1_addr == ADDR_W'(i))) ||
                         (w_wr0_ok && (wr0_addr == ADDR_W'(i))))
                    r_pend[i] <= 1'b0;
            end
        end
    end

    // Combinational read ports, with optional forwarding of the write being
    // committed this cycle; the zero register always reads as idle zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_ra    = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra                        = rd_addr[p*ADDR_W +: ADDR_W];
            rd_data[p*DATA_W +: DATA_W] = r_regs[w_ra];
            rd_busy[p]                  = r_pend[w_ra];
`ifdef GPR_BYPASS_EN
            if (w_wr1_ok && (wr1_addr == w_ra)) begin
                rd_data[p*DATA_W +: DATA_W] = wr1_data;
                rd_busy[p]                  = w_sb_ok && (sb_set_addr == w_ra);
            end else if (w_wr0_ok && (wr0_addr == w_ra)) begin
                rd_data[p*DATA_W +: DATA_W] = wr0_data;
                rd_busy[p]                  = w_sb_ok && (sb_set_addr == w_ra);
            end
`endif
            if (is_zero_reg(w_ra)) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
                rd_busy[p]                  = 1'b0;
            end
        end
    end

endmodule
